// File: rtl/lsr_window_sched.sv
// Sliding-window scheduler for the least-squares fit engine: circular sample buffer,
// fit launch/handshake sequencing and result capture. Optional fit watchdog: LSR_SCHED_WDOG_EN.
module lsr_window_sched #(
    parameter int DATA_SIZE = 50,
    parameter int TIMEOUT   = 65535,
    parameter int IW        = $clog2(DATA_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [15:0]   s_data,
    input  logic [15:0]   shift,
    output logic          fit_start,
    input  logic          fit_done,
    input  logic [15:0]   fit_val,
    input  logic [IW-1:0] rd_idx,
    output logic [15:0]   rd_data,
    output logic          res_valid,
    output logic [15:0]   res_val,
    output logic [15:0]   fit_count,
    output logic          err_timeout
);

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_LAUNCH  = 2'd2;
    localparam logic [1:0] ST_WAIT    = 2'd3;

    localparam logic [15:0]   DS_16     = 16'(DATA_SIZE);
    localparam logic [IW:0]   DS_W      = (IW + 1)'(DATA_SIZE);
    localparam logic [IW:0]   FILL_LAST = (IW + 1)'(DATA_SIZE - 1);
    localparam logic [IW-1:0] LAST_PTR  = IW'(DATA_SIZE - 1);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT - 1);

`ifdef LSR_SCHED_WDOG_EN
    localparam logic WDOG_EN = 1'b1;
`else
    localparam logic WDOG_EN = 1'b0;
`endif

    logic [1:0]    state_r;
    logic [1:0]    state_nx_s;
    logic [15:0]   mem_r [DATA_SIZE];
    logic [IW-1:0] wr_ptr_r;
    logic [IW:0]   fill_cnt_r;
    logic [15:0]   new_cnt_r;
    logic [15:0]   shift_l_r;
    logic [15:0]   shift_clamp_s;
    logic [15:0]   wdog_r;
    logic          fit_start_r;
    logic          res_valid_r;
    logic [15:0]   res_val_r;
    logic [15:0]   fit_count_r;
    logic          err_timeout_r;
    logic [15:0]   rd_data_r;
    logic [IW:0]   rd_sum_s;
    logic [IW-1:0] rd_phys_s;
    logic          rd_oob_s;
    logic          s_ready_s;
    logic          accept_s;
    logic          done_s;
    logic          timeout_s;
    logic          enter_collect_s;

    // Handshake qualifiers; ready is gated by rst_n so it drops the instant reset asserts
    always_comb begin
        s_ready_s       = rst_n && ((state_r == ST_FILL) || (state_r == ST_COLLECT));
        accept_s        = s_valid && s_ready_s;
        done_s          = (state_r == ST_WAIT) && fit_done;
        timeout_s       = WDOG_EN && (state_r == ST_WAIT) && !fit_done && (wdog_r == TO_LAST);
        enter_collect_s = done_s || timeout_s;
    end

    // Clamp requested shift into 1..DATA_SIZE, zero treated as one
    always_comb begin
        shift_clamp_s = shift;
        if (shift == 16'd0) begin
            shift_clamp_s = 16'd1;
        end else if (shift > DS_16) begin
            shift_clamp_s = DS_16;
        end else begin
            shift_clamp_s = shift;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (accept_s && (fill_cnt_r == FILL_LAST)) begin
                    state_nx_s = ST_LAUNCH;
                end else begin
                    state_nx_s = ST_FILL;
                end
            end
            ST_COLLECT: begin
                if (accept_s && ((new_cnt_r + 16'd1) == shift_l_r)) begin
                    state_nx_s = ST_LAUNCH;
                end else begin
                    state_nx_s = ST_COLLECT;
                end
            end
            ST_LAUNCH: state_nx_s = ST_WAIT;
            ST_WAIT: begin
                if (enter_collect_s) begin
                    state_nx_s = ST_COLLECT;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: state_nx_s = ST_FILL;
        endcase
    end

    // State register and launch pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            fit_start_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            fit_start_r <= (state_nx_s == ST_LAUNCH);
        end
    end

    // Fill and per-fit sample counters; shift is sampled only when COLLECT is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_r <= {(IW + 1){1'b0}};
            new_cnt_r  <= 16'd0;
            shift_l_r  <= 16'd1;
        end else begin
            if (accept_s && (state_r == ST_FILL)) begin
                fill_cnt_r <= fill_cnt_r + (IW + 1)'(1);
            end
            if (enter_collect_s) begin
                shift_l_r <= shift_clamp_s;
                new_cnt_r <= 16'd0;
            end else if (accept_s && (state_r == ST_COLLECT)) begin
                new_cnt_r <= new_cnt_r + 16'd1;
            end
        end
    end

    // Watchdog counter, restarted while launching so WAIT begins at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= 16'd0;
        end else if (state_r == ST_LAUNCH) begin
            wdog_r <= 16'd0;
        end else if (state_r == ST_WAIT) begin
            wdog_r <= wdog_r + 16'd1;
        end
    end

    // Result capture, fit counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r   <= 1'b0;
            res_val_r     <= 16'd0;
            fit_count_r   <= 16'd0;
            err_timeout_r <= 1'b0;
        end else begin
            res_valid_r <= done_s;
            if (done_s) begin
                res_val_r   <= fit_val;
                fit_count_r <= fit_count_r + 16'd1;
            end
            if (timeout_s) begin
                err_timeout_r <= 1'b1;
            end
        end
    end

    // Circular sample buffer, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                mem_r[i] <= 16'd0;
            end
            wr_ptr_r <= {IW{1'b0}};
        end else if (accept_s) begin
            mem_r[wr_ptr_r] <= s_data;
            wr_ptr_r        <= (wr_ptr_r == LAST_PTR) ? {IW{1'b0}} : wr_ptr_r + IW'(1);
        end
    end

    // Oldest-first mapping: wr_ptr points at the oldest entry once the window is full
    always_comb begin
        rd_sum_s  = {1'b0, wr_ptr_r} + {1'b0, rd_idx};
        rd_oob_s  = ({1'b0, rd_idx} >= DS_W);
        rd_phys_s = rd_sum_s[IW-1:0];
        if (rd_sum_s >= DS_W) begin
            rd_phys_s = IW'(rd_sum_s - DS_W);
        end else begin
            rd_phys_s = rd_sum_s[IW-1:0];
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 16'd0;
        end else if (rd_oob_s) begin
            rd_data_r <= 16'd0;
        end else begin
            rd_data_r <= mem_r[rd_phys_s];
        end
    end

    assign s_ready     = s_ready_s;
    assign fit_start   = fit_start_r;
    assign rd_data     = rd_data_r;
    assign res_valid   = res_valid_r;
    assign res_val     = res_val_r;
    assign fit_count   = fit_count_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_lsr_window_sched.sv
// Directed bench for lsr_window_sched with DATA_SIZE=8, TIMEOUT=20.
// Watchdog expectations follow LSR_SCHED_WDOG_EN.
module tb_lsr_window_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = 16'd0;
    logic [15:0] shift = 16'd1;
    logic        fit_start;
    logic        fit_done = 1'b0;
    logic [15:0] fit_val = 16'd0;
    logic [2:0]  rd_idx = 3'd0;
    logic [15:0] rd_data;
    logic        res_valid;
    logic [15:0] res_val;
    logic [15:0] fit_count;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    lsr_window_sched #(.DATA_SIZE(8), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .shift(shift), .fit_start(fit_start), .fit_done(fit_done), .fit_val(fit_val),
        .rd_idx(rd_idx), .rd_data(rd_data), .res_valid(res_valid), .res_val(res_val),
        .fit_count(fit_count), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks += 4;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
        if (fit_start !== 1'b0) begin n_fail++; $display("FAIL reset_fit_start got %b exp 0", fit_start); end
        if (rd_data !== 16'd0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        if ({res_valid, res_val, fit_count, err_timeout} !== 34'd0) begin
            n_fail++; $display("FAIL reset_results got %b %h %h %b exp zeros", res_valid, res_val, fit_count, err_timeout);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL release_s_ready got %b exp 1", s_ready); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            n_checks++;
            if (s_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got %b exp 1", i, s_ready); end
            tick();
            n_checks++;
            if (fit_start !== (i == 8)) begin
                n_fail++; $display("FAIL fill_start[%0d] got %b exp %b", i, fit_start, (i == 8));
            end
        end
        s_data = 16'd99;
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL launch_ready got %b exp 0", s_ready); end
        tick();
        n_checks += 2;
        if (fit_start !== 1'b0) begin n_fail++; $display("FAIL start_once got %b exp 0", fit_start); end
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL wait_ready got %b exp 0", s_ready); end
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            tick();
            n_checks++;
            if (rd_data !== 16'(k + 1)) begin
                n_fail++; $display("FAIL fill_read[%0d] got %0d exp %0d", k, rd_data, k + 1);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_slide();
        shift    = 16'd3;
        fit_done = 1'b1;
        fit_val  = 16'hFFFB;
        tick();
        fit_done = 1'b0;
        n_checks += 4;
        if (res_valid !== 1'b1) begin n_fail++; $display("FAIL slide_res_valid got %b exp 1", res_valid); end
        if (res_val !== 16'hFFFB) begin n_fail++; $display("FAIL slide_res_val got %h exp fffb", res_val); end
        if (fit_count !== 16'd1) begin n_fail++; $display("FAIL slide_count got %0d exp 1", fit_count); end
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL slide_ready got %b exp 1", s_ready); end
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL slide_res_once got %b exp 0", res_valid); end
        for (int i = 9; i <= 11; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            tick();
            n_checks++;
            if (fit_start !== (i == 11)) begin
                n_fail++; $display("FAIL slide_start[%0d] got %b exp %b", i, fit_start, (i == 11));
            end
        end
        s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            tick();
            n_checks++;
            if (rd_data !== 16'(k + 4)) begin
                n_fail++; $display("FAIL slide_read[%0d] got %0d exp %0d", k, rd_data, k + 4);
            end
        end
    endtask

    task automatic test_clamp();
        shift    = 16'd0;
        fit_done = 1'b1;
        fit_val  = 16'd7;
        tick();
        fit_done = 1'b0;
        s_valid  = 1'b1;
        s_data   = 16'd12;
        tick();
        s_valid  = 1'b0;
        n_checks++;
        if (fit_start !== 1'b1) begin n_fail++; $display("FAIL clamp0_start got %b exp 1", fit_start); end
        tick();
        shift    = 16'd100;
        fit_done = 1'b1;
        fit_val  = 16'd4;
        tick();
        fit_done = 1'b0;
        for (int i = 13; i <= 20; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            tick();
            n_checks++;
            if (fit_start !== (i == 20)) begin
                n_fail++; $display("FAIL clamp100_start[%0d] got %b exp %b", i, fit_start, (i == 20));
            end
        end
        s_valid  = 1'b0;
        tick();
        fit_done = 1'b1;
        tick();
        fit_done = 1'b0;
        n_checks++;
        if (fit_count !== 16'd4) begin n_fail++; $display("FAIL clamp_count got %0d exp 4", fit_count); end
    endtask

    task automatic test_stray_done();
        fit_done = 1'b1;
        fit_val  = 16'd123;
        tick();
        fit_done = 1'b0;
        n_checks += 3;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL stray_res_valid got %b exp 0", res_valid); end
        if (fit_count !== 16'd4) begin n_fail++; $display("FAIL stray_count got %0d exp 4", fit_count); end
        if (res_val !== 16'd4) begin n_fail++; $display("FAIL stray_res_val got %0d exp 4", res_val); end
    endtask

    task automatic test_watchdog();
        for (int i = 21; i <= 28; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            tick();
        end
        n_checks++;
        if (fit_start !== 1'b1) begin n_fail++; $display("FAIL wdog_launch got %b exp 1", fit_start); end
        s_data = 16'd555;
        for (int t = 1; t <= 20; t++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b0 || s_ready !== 1'b0 || err_timeout !== 1'b0) begin
                n_fail++; $display("FAIL wdog_wait[%0d] got rv=%b rdy=%b err=%b exp 0 0 0", t, res_valid, s_ready, err_timeout);
            end
        end
        s_valid = 1'b0;
        tick();
        n_checks += 2;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL wdog_res_valid got %b exp 0", res_valid); end
        if (fit_count !== 16'd4) begin n_fail++; $display("FAIL wdog_count got %0d exp 4", fit_count); end
`ifdef LSR_SCHED_WDOG_EN
        n_checks += 2;
        if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL wdog_err got %b exp 1", err_timeout); end
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL wdog_ready got %b exp 1", s_ready); end
        for (int i = 29; i <= 36; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            tick();
        end
        s_valid = 1'b0;
        tick();
`else
        n_checks += 2;
        if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL wdog_off_err got %b exp 0", err_timeout); end
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL wdog_off_ready got %b exp 0", s_ready); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL pre_reset_wait got %b exp 0", s_ready); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (s_ready !== 1'b0 || fit_start !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_hs got rdy=%b st=%b exp 0 0", s_ready, fit_start);
        end
        if (rd_data !== 16'd0 || res_valid !== 1'b0 || res_val !== 16'd0) begin
            n_fail++; $display("FAIL rst_async_data got rd=%h rv=%b val=%h exp zeros", rd_data, res_valid, res_val);
        end
        if (fit_count !== 16'd0 || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_cnt got %0d %b exp 0 0", fit_count, err_timeout);
        end
        tick();
        #2;
        rst_n    = 1'b1;
        rd_idx   = 3'd3;
        fit_done = 1'b1;
        fit_val  = 16'd77;
        tick();
        fit_done = 1'b0;
        n_checks += 3;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL late_done_res got %b exp 0", res_valid); end
        if (fit_count !== 16'd0) begin n_fail++; $display("FAIL late_done_count got %0d exp 0", fit_count); end
        if (rd_data !== 16'd0) begin n_fail++; $display("FAIL cleared_read got %0d exp 0", rd_data); end
        for (int i = 31; i <= 38; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            tick();
            n_checks++;
            if (fit_start !== (i == 38)) begin
                n_fail++; $display("FAIL refill_start[%0d] got %b exp %b", i, fit_start, (i == 38));
            end
        end
        s_valid = 1'b0;
        rd_idx  = 3'd0;
        tick();
        n_checks++;
        if (rd_data !== 16'd31) begin n_fail++; $display("FAIL refill_read0 got %0d exp 31", rd_data); end
        rd_idx = 3'd7;
        tick();
        n_checks++;
        if (rd_data !== 16'd38) begin n_fail++; $display("FAIL refill_read7 got %0d exp 38", rd_data); end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got expired exp finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_fill();
        test_slide();
        test_clamp();
        test_stray_done();
        test_watchdog();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
